// File: rtl/sr_pkg.sv
// Shared definitions for the clocked SR storage bank: conflict policies and
// the next-state function used by both the RTL and the reference model.
package sr_pkg;

    localparam int MODE_HOLD       = 0;
    localparam int MODE_SET_WINS   = 1;
    localparam int MODE_RESET_WINS = 2;
    localparam int MODE_TOGGLE     = 3;

    localparam int N_CH_MAX        = 32;
    localparam int SYNC_STAGES_MAX = 3;

    typedef enum logic [1:0] {
        IN_IDLE     = 2'b00,
        IN_RESET    = 2'b01,
        IN_SET      = 2'b10,
        IN_CONFLICT = 2'b11
    } sr_in_e;

    function automatic sr_in_e sr_classify(input logic s, input logic r);
        return sr_in_e'({s, r});
    endfunction

    function automatic logic sr_next(input logic q, input logic s, input logic r,
                                     input int mode);
        logic q_nxt;
        q_nxt = q;
        case (sr_classify(s, r))
            IN_IDLE:  q_nxt = q;
            IN_SET:   q_nxt = 1'b1;
            IN_RESET: q_nxt = 1'b0;
            IN_CONFLICT: begin
                case (mode)
                    MODE_SET_WINS:   q_nxt = 1'b1;
                    MODE_RESET_WINS: q_nxt = 1'b0;
                    MODE_TOGGLE:     q_nxt = ~q;
                    default:         q_nxt = q;
                endcase
            end
            default:  q_nxt = q;
        endcase
        return q_nxt;
    endfunction

endpackage

// File: rtl/sr_cell.sv
// One storage channel: optional input synchroniser, the q flop, and the
// registered changed / sticky conflict flags.
module sr_cell
    import sr_pkg::*;
#(
    parameter int   MODE        = MODE_HOLD,
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sbar,
    input  logic i_rbar,
    input  logic i_clr_conflict,
    output logic o_q,
    output logic o_changed,
    output logic o_conflict,
    output logic o_conflict_now
);

    logic w_sbar_sync;
    logic w_rbar_sync;
    logic w_s;
    logic w_r;
    logic w_q_next;

    logic r_q;
    logic r_changed;
    logic r_conflict;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_sbar_sync = i_sbar;
            assign w_rbar_sync = i_rbar;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sbar_pipe;
            logic [SYNC_STAGES-1:0] r_rbar_pipe;

            // NOTE: synchroniser flops reset to 1 so a reset flushes any pending
            // active-low request instead of replaying it after deassertion.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sbar_pipe <= '1;
                    r_rbar_pipe <= '1;
                end else begin
                    r_sbar_pipe[0] <= i_sbar;
                    r_rbar_pipe[0] <= i_rbar;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        r_sbar_pipe[k] <= r_sbar_pipe[k-1];
                        r_rbar_pipe[k] <= r_rbar_pipe[k-1];
                    end
                end
            end

            assign w_sbar_sync = r_sbar_pipe[SYNC_STAGES-1];
            assign w_rbar_sync = r_rbar_pipe[SYNC_STAGES-1];
        end
    endgenerate

    assign w_s      = ~w_sbar_sync;
    assign w_r      = ~w_rbar_sync;
    assign w_q_next = sr_next(r_q, w_s, w_r, MODE);

    // NOTE: all state updates use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q        <= RESET_VAL;
            r_changed  <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_q       <= w_q_next;
            r_changed <= w_q_next ^ r_q;
            // A fresh conflict beats a simultaneous clear.
            if (w_s && w_r) begin
                r_conflict <= 1'b1;
            end else if (i_clr_conflict) begin
                r_conflict <= 1'b0;
            end
        end
    end

    assign o_q            = r_q;
    assign o_changed      = r_changed;
    assign o_conflict     = r_conflict;
    assign o_conflict_now = w_s & w_r;

endmodule

// File: rtl/sr_latch_bank.sv
// Bank of N_CH clocked set/reset channels with a selectable conflict policy,
// sticky per-channel conflict flags and a saturating conflict-cycle counter.
module sr_latch_bank
    import sr_pkg::*;
#(
    parameter int              N_CH        = 8,
    parameter int              MODE        = MODE_HOLD,
    parameter int              SYNC_STAGES = 2,
    parameter logic [N_CH-1:0] RESET_VAL   = {N_CH{1'b0}},
    parameter int              CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  sbar,
    input  logic [N_CH-1:0]  rbar,
    input  logic             clr_conflict,
    output logic [N_CH-1:0]  q,
    output logic [N_CH-1:0]  qbar,
    output logic [N_CH-1:0]  changed,
    output logic [N_CH-1:0]  conflict,
    output logic [CNT_W-1:0] conflict_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    generate
        if (MODE < MODE_HOLD || MODE > MODE_TOGGLE) begin : g_bad_mode
            $error("sr_latch_bank: MODE must be 0..3");
        end
        if (N_CH < 1 || N_CH > N_CH_MAX) begin : g_bad_nch
            $error("sr_latch_bank: N_CH must be 1..32");
        end
        if (SYNC_STAGES < 0 || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
            $error("sr_latch_bank: SYNC_STAGES must be 0..3");
        end
        if (CNT_W < 1) begin : g_bad_cntw
            $error("sr_latch_bank: CNT_W must be at least 1");
        end
    endgenerate

    logic [N_CH-1:0]  w_q;
    logic [N_CH-1:0]  w_changed;
    logic [N_CH-1:0]  w_conflict;
    logic [N_CH-1:0]  w_conflict_now;
    logic             w_any_conflict;
    logic [CNT_W-1:0] w_count_next;

    logic [CNT_W-1:0] r_conflict_count;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            sr_cell #(
                .MODE        (MODE),
                .SYNC_STAGES (SYNC_STAGES),
                .RESET_VAL   (RESET_VAL[i])
            ) u_cell (
                .clk            (clk),
                .rst_n          (rst_n),
                .i_sbar         (sbar[i]),
                .i_rbar         (rbar[i]),
                .i_clr_conflict (clr_conflict),
                .o_q            (w_q[i]),
                .o_changed      (w_changed[i]),
                .o_conflict     (w_conflict[i]),
                .o_conflict_now (w_conflict_now[i])
            );
        end
    endgenerate

    assign w_any_conflict = |w_conflict_now;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and infers a latch.
    always_comb begin
        w_count_next = r_conflict_count;
        if (clr_conflict) begin
            w_count_next = w_any_conflict ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
        end else if (w_any_conflict && (r_conflict_count != CNT_MAX)) begin
            w_count_next = r_conflict_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict_count <= '0;
        end else begin
            r_conflict_count <= w_count_next;
        end
    end

    assign q              = w_q;
    assign qbar           = ~w_q;
    assign changed        = w_changed;
    assign conflict       = w_conflict;
    assign conflict_count = r_conflict_count;

endmodule

// File: tb/tb_sr_latch_bank.sv
// Directed bench: four conflict-policy instances (SYNC_STAGES=2) plus one
// unsynchronised instance with a 2-bit counter, all sharing the same stimulus.
module tb_sr_latch_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sbar;
    logic [3:0] rbar;
    logic       clr;

    logic [3:0] m_q    [4];
    logic [3:0] m_qbar [4];
    logic [3:0] m_chg  [4];
    logic [3:0] m_conf [4];
    logic [7:0] m_cnt  [4];

    logic [3:0] s_q, s_qbar, s_chg, s_conf;
    logic [1:0] s_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : g_mode
        sr_latch_bank #(
            .N_CH(4), .MODE(m), .SYNC_STAGES(2), .RESET_VAL(4'b1010), .CNT_W(8)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .sbar(sbar), .rbar(rbar), .clr_conflict(clr),
            .q(m_q[m]), .qbar(m_qbar[m]), .changed(m_chg[m]),
            .conflict(m_conf[m]), .conflict_count(m_cnt[m])
        );
    end

    sr_latch_bank #(
        .N_CH(4), .MODE(0), .SYNC_STAGES(0), .RESET_VAL(4'b1010), .CNT_W(2)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .sbar(sbar), .rbar(rbar), .clr_conflict(clr),
        .q(s_q), .qbar(s_qbar), .changed(s_chg),
        .conflict(s_conf), .conflict_count(s_cnt)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        sbar  = 4'hF;
        rbar  = 4'hF;
        clr   = 1'b0;

        // Reset state
        #12;
        check("rst_q",      8'(m_q[0]),    8'h0A);
        check("rst_qbar",   8'(m_qbar[0]), 8'h05);
        check("rst_conf",   8'(m_conf[0]), 8'h00);
        check("rst_cnt",    m_cnt[0],      8'h00);
        check("rst_chg",    8'(m_chg[0]),  8'h00);
        check("rst_sat_q",  8'(s_q),       8'h0A);
        rst_n = 1'b1;
        step();
        check("idle_q", 8'(m_q[0]), 8'h0A);

        // One-cycle set on channel 0: 3 edges with sync, 1 edge without
        sbar = 4'b1110;
        step();
        check("set_e1_q",     8'(m_q[0]), 8'h0A);
        check("set_e1_sat_q", 8'(s_q),    8'h0B);
        check("set_e1_sat_c", 8'(s_chg),  8'h01);
        sbar = 4'hF;
        step();
        check("set_e2_q",     8'(m_q[0]), 8'h0A);
        check("set_e2_sat_c", 8'(s_chg),  8'h00);
        step();
        check("set_e3_q",     8'(m_q[0]),  8'h0B);
        check("set_e3_chg",   8'(m_chg[0]), 8'h01);
        check("set_e3_qbar",  8'(m_qbar[0]), 8'h04);
        step();
        check("set_e4_chg",   8'(m_chg[0]), 8'h00);
        check("set_e4_q",     8'(m_q[0]),   8'h0B);

        // Clear channel 1 so every policy starts from q[1]=0
        rbar = 4'b1101;
        step();
        check("clr1_sat_q", 8'(s_q), 8'h09);
        rbar = 4'hF;
        step();
        step();
        check("clr1_q",   8'(m_q[0]),   8'h09);
        check("clr1_chg", 8'(m_chg[0]), 8'h02);
        step();

        // Conflict on channel 1 for 3 cycles under every policy
        sbar = 4'b1101;
        rbar = 4'b1101;
        step();
        step();
        step();
        check("f3_hold_q",   8'(m_q[0]), 8'h09);
        check("f3_set_q",    8'(m_q[1]), 8'h0B);
        check("f3_reset_q",  8'(m_q[2]), 8'h09);
        check("f3_tog_q",    8'(m_q[3]), 8'h0B);
        check("f3_sat_cnt",  8'(s_cnt),  8'h03);
        check("f3_sat_conf", 8'(s_conf), 8'h02);
        check("f3_sat_q",    8'(s_q),    8'h09);
        sbar = 4'hF;
        rbar = 4'hF;
        step();
        check("f4_tog_q",   8'(m_q[3]),   8'h09);
        check("f4_tog_chg", 8'(m_chg[3]), 8'h02);
        check("f4_set_chg", 8'(m_chg[1]), 8'h00);
        step();
        check("f5_tog_q", 8'(m_q[3]), 8'h0B);
        for (int m = 0; m < 4; m++) begin
            check($sformatf("f5_cnt_m%0d", m),  m_cnt[m],      8'h03);
            check($sformatf("f5_conf_m%0d", m), 8'(m_conf[m]), 8'h02);
        end
        check("f5_hold_q",  8'(m_q[0]), 8'h09);
        check("f5_set_q",   8'(m_q[1]), 8'h0B);
        check("f5_reset_q", 8'(m_q[2]), 8'h09);
        step();
        check("f6_tog_chg", 8'(m_chg[3]), 8'h00);
        check("f6_cnt",     m_cnt[0],     8'h03);

        // Clear pulse
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_cnt",      m_cnt[0],      8'h00);
        check("clr_conf",     8'(m_conf[0]), 8'h00);
        check("clr_sat_cnt",  8'(s_cnt),     8'h00);
        check("clr_sat_conf", 8'(s_conf),    8'h00);

        // Six conflict cycles on channel 0: 2-bit counter saturates at 3
        sbar = 4'b1110;
        rbar = 4'b1110;
        step();
        step();
        check("sat_h2_cnt", 8'(s_cnt), 8'h02);
        step();
        step();
        step();
        step();
        check("sat_h6_cnt",  8'(s_cnt),  8'h03);
        check("sat_h6_conf", 8'(s_conf), 8'h01);
        check("sat_h6_q",    8'(s_q),    8'h09);
        sbar = 4'hF;
        rbar = 4'hF;
        step();
        step();
        check("h8_cnt",     m_cnt[0],      8'h06);
        check("h8_set_cnt", m_cnt[1],      8'h06);
        check("h8_conf",    8'(m_conf[0]), 8'h01);
        check("h8_hold_q",  8'(m_q[0]),    8'h09);
        check("h8_reset_q", 8'(m_q[2]),    8'h08);
        check("h8_tog_q",   8'(m_q[3]),    8'h0B);
        check("h8_sat_cnt", 8'(s_cnt),     8'h03);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("h9_sat_cnt",  8'(s_cnt),  8'h00);
        check("h9_sat_conf", 8'(s_conf), 8'h00);
        check("h9_cnt",      m_cnt[0],   8'h00);

        // Clear colliding with a new conflict on channel 2
        clr  = 1'b1;
        sbar = 4'b1011;
        rbar = 4'b1011;
        step();
        check("col_sat_conf", 8'(s_conf),    8'h04);
        check("col_sat_cnt",  8'(s_cnt),     8'h01);
        check("col_m0_conf",  8'(m_conf[0]), 8'h00);
        clr  = 1'b0;
        sbar = 4'hF;
        rbar = 4'hF;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("col_m0_conf2", 8'(m_conf[0]), 8'h04);
        check("col_m0_cnt2",  m_cnt[0],      8'h01);
        check("col_sat_clr",  8'(s_conf),    8'h00);
        check("col_sat_cnt0", 8'(s_cnt),     8'h00);

        // Mid-operation asynchronous reset with a held set on channel 2
        sbar = 4'b1011;
        step();
        step();
        step();
        check("mr_pre_q",   8'(m_q[0]),   8'h0D);
        check("mr_pre_chg", 8'(m_chg[0]), 8'h04);
        #3;
        rst_n = 1'b0;
        #1;
        check("mr_q",     8'(m_q[0]),    8'h0A);
        check("mr_qbar",  8'(m_qbar[0]), 8'h05);
        check("mr_cnt",   m_cnt[0],      8'h00);
        check("mr_conf",  8'(m_conf[0]), 8'h00);
        check("mr_sat_q", 8'(s_q),       8'h0A);
        #2;
        rst_n = 1'b1;
        step();
        check("mr_j4_q",     8'(m_q[0]), 8'h0A);
        check("mr_j4_sat_q", 8'(s_q),    8'h0E);
        step();
        check("mr_j5_q", 8'(m_q[0]), 8'h0A);
        step();
        check("mr_j6_q",   8'(m_q[0]),   8'h0E);
        check("mr_j6_chg", 8'(m_chg[0]), 8'h04);

        // Held set on an already-set channel 3
        sbar = 4'b0111;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("idem_chg_%0d", k),  8'(m_chg[0]),  8'h00);
            check($sformatf("idem_conf_%0d", k), 8'(m_conf[0]), 8'h00);
        end
        sbar = 4'hF;
        step();
        step();
        step();
        check("idem_q",      8'(m_q[0]), 8'h0E);
        check("idem_chg",    8'(m_chg[0]), 8'h00);
        check("idem_sat_q",  8'(s_q),    8'h0E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
